// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter: data master m0 and read-only instruction master m1
// share one slave, with round-robin tie-break and a forced-error watchdog per transfer.
module wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic [31:0] m1_addr_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic [31:0] s_addr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,

    output logic        timeout_o
);

    typedef enum logic [1:0] {
        IDLE,
        GNT_M0,
        GNT_M1
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic       last_gnt;       // 0: m0 won last, 1: m1 won last
    logic       last_gnt_next;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_next;

    logic       m0_req;
    logic       m1_req;
    logic       gnt_cyc;
    logic       slave_done;
    logic       timeout_hit;

    always_comb begin
        m0_req     = m0_cyc_i & m0_stb_i;
        m1_req     = m1_cyc_i & m1_stb_i;
        slave_done = s_ack_i | s_err_i;

        gnt_cyc = 1'b0;
        case (state)
            GNT_M0:  gnt_cyc = m0_cyc_i;
            GNT_M1:  gnt_cyc = m1_cyc_i;
            default: gnt_cyc = 1'b0;
        endcase

        // A real slave response in the last allowed cycle beats the watchdog.
        timeout_hit = (state != IDLE) && gnt_cyc && !slave_done && (wait_cnt == WAIT_LAST);
    end

    always_comb begin
        state_next    = state;
        last_gnt_next = last_gnt;
        wait_cnt_next = wait_cnt;

        case (state)
            IDLE: begin
                wait_cnt_next = 8'd0;
                if (m0_req && (!m1_req || last_gnt)) begin
                    state_next    = GNT_M0;
                    last_gnt_next = 1'b0;
                end else if (m1_req) begin
                    state_next    = GNT_M1;
                    last_gnt_next = 1'b1;
                end
            end
            GNT_M0, GNT_M1: begin
                if (slave_done || !gnt_cyc || timeout_hit) begin
                    state_next    = IDLE;
                    wait_cnt_next = 8'd0;
                end else begin
                    wait_cnt_next = wait_cnt + 8'd1;
                end
            end
            default: begin
                state_next    = IDLE;
                wait_cnt_next = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            last_gnt <= last_gnt_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Bus steering is purely combinational; holding rst_i low silences every
    // control strobe even in the cycle before the state register clears.
    always_comb begin
        s_addr_o  = 32'd0;
        s_dat_o   = 32'd0;
        s_sel_o   = 4'd0;
        s_we_o    = 1'b0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        m0_dat_o  = s_dat_i;
        m1_dat_o  = s_dat_i;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        timeout_o = 1'b0;

        if (rst_i) begin
            case (state)
                GNT_M0: begin
                    s_addr_o  = m0_addr_i;
                    s_dat_o   = m0_dat_i;
                    s_sel_o   = m0_sel_i;
                    s_we_o    = m0_we_i;
                    s_cyc_o   = m0_cyc_i & ~timeout_hit;
                    s_stb_o   = m0_stb_i & ~timeout_hit;
                    m0_ack_o  = s_ack_i & ~s_err_i;
                    m0_err_o  = s_err_i | timeout_hit;
                    timeout_o = timeout_hit;
                end
                GNT_M1: begin
                    s_addr_o  = m1_addr_i;
                    s_dat_o   = 32'd0;
                    s_sel_o   = 4'hF;
                    s_we_o    = 1'b0;
                    s_cyc_o   = m1_cyc_i & ~timeout_hit;
                    s_stb_o   = m1_stb_i & ~timeout_hit;
                    m1_ack_o  = s_ack_i & ~s_err_i;
                    m1_err_o  = s_err_i | timeout_hit;
                    timeout_o = timeout_hit;
                end
                default: begin
                    s_cyc_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations plus a
// transaction-level ownership model compared against the DUT every cycle.
module tb_wb_arbiter;

    localparam int TO = 4;

    logic        clk;
    logic        rst_i;
    logic [31:0] m0_addr_i, m0_dat_i;
    logic [3:0]  m0_sel_i;
    logic        m0_we_i, m0_cyc_i, m0_stb_i;
    logic [31:0] m0_dat_o;
    logic        m0_ack_o, m0_err_o;
    logic [31:0] m1_addr_i;
    logic        m1_cyc_i, m1_stb_i;
    logic [31:0] m1_dat_o;
    logic        m1_ack_o, m1_err_o;
    logic [31:0] s_addr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i, s_err_i;
    logic        timeout_o;

    wb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_addr_i(m0_addr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_addr_i(m1_addr_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_addr_o(s_addr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: who owns the slave (-1 nobody), who won last, cycles spent waiting.
    int mdl_owner = -1;
    int mdl_last  = 1;
    int mdl_wait  = 0;

    function automatic bit own_cyc();
        return (mdl_owner == 0) ? m0_cyc_i : m1_cyc_i;
    endfunction

    function automatic bit own_stb();
        return (mdl_owner == 0) ? m0_stb_i : m1_stb_i;
    endfunction

    always @(posedge clk) begin
        bit r0, r1;
        r0 = m0_cyc_i && m0_stb_i;
        r1 = m1_cyc_i && m1_stb_i;
        if (!rst_i) begin
            mdl_owner = -1;
            mdl_last  = 1;
            mdl_wait  = 0;
        end else if (mdl_owner < 0) begin
            if (r0 && r1)  mdl_owner = 1 - mdl_last;
            else if (r0)   mdl_owner = 0;
            else if (r1)   mdl_owner = 1;
            if (mdl_owner >= 0) mdl_last = mdl_owner;
            mdl_wait = 0;
        end else if (s_ack_i || s_err_i || !own_cyc() || mdl_wait == TO - 1) begin
            mdl_owner = -1;
            mdl_wait  = 0;
        end else begin
            mdl_wait++;
        end
    end

    always @(negedge clk) begin
        bit e_cyc, e_stb, e_we, e_ack, e_err, e_to;
        e_cyc = 0; e_stb = 0; e_we = 0; e_ack = 0; e_err = 0; e_to = 0;
        if (chk_en) begin
            if (rst_i && mdl_owner >= 0) begin
                e_to  = own_cyc() && !s_ack_i && !s_err_i && (mdl_wait == TO - 1);
                e_cyc = own_cyc() && !e_to;
                e_stb = own_stb() && !e_to;
                e_we  = (mdl_owner == 0) ? m0_we_i : 1'b0;
                e_ack = s_ack_i && !s_err_i;
                e_err = s_err_i || e_to;
                chk("mdl_addr", s_addr_o, (mdl_owner == 0) ? m0_addr_i : m1_addr_i);
                chk("mdl_sdat", s_dat_o,  (mdl_owner == 0) ? m0_dat_i : 32'd0);
                chk("mdl_sel",  {28'd0, s_sel_o}, (mdl_owner == 0) ? {28'd0, m0_sel_i} : 32'hF);
            end
            chk("mdl_cyc",    {31'd0, s_cyc_o},   {31'd0, e_cyc});
            chk("mdl_stb",    {31'd0, s_stb_o},   {31'd0, e_stb});
            chk("mdl_we",     {31'd0, s_we_o},    {31'd0, e_we});
            chk("mdl_m0_ack", {31'd0, m0_ack_o},  {31'd0, e_ack && mdl_owner == 0});
            chk("mdl_m0_err", {31'd0, m0_err_o},  {31'd0, e_err && mdl_owner == 0});
            chk("mdl_m1_ack", {31'd0, m1_ack_o},  {31'd0, e_ack && mdl_owner == 1});
            chk("mdl_m1_err", {31'd0, m1_err_o},  {31'd0, e_err && mdl_owner == 1});
            chk("mdl_to",     {31'd0, timeout_o}, {31'd0, e_to});
            chk("mdl_m0_dat", m0_dat_o, s_dat_i);
            chk("mdl_m1_dat", m1_dat_o, s_dat_i);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_all();
        m0_addr_i = 32'd0; m0_dat_i = 32'd0; m0_sel_i = 4'd0; m0_we_i = 1'b0;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m1_addr_i = 32'd0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        s_dat_i = 32'd0; s_ack_i = 1'b0; s_err_i = 1'b0;
    endtask

    task automatic req_m0(input logic [31:0] a);
        m0_addr_i = a; m0_dat_i = 32'h1234_5678; m0_sel_i = 4'hF;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    endtask

    task automatic req_m1(input logic [31:0] a);
        m1_addr_i = a; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    endtask

    initial begin
        rst_i = 1'b0;
        idle_all();
        step();
        chk_en = 1'b1;

        // Reset: requests and slave strobes present, nothing must leak out.
        req_m0(32'h10); req_m1(32'h20); s_ack_i = 1'b1; s_err_i = 1'b1;
        settle();
        chk("rst_cyc", {31'd0, s_cyc_o}, 32'd0);
        chk("rst_m0_ack", {31'd0, m0_ack_o}, 32'd0);
        chk("rst_m1_err", {31'd0, m1_err_o}, 32'd0);
        chk("rst_to", {31'd0, timeout_o}, 32'd0);
        step();
        idle_all();
        rst_i = 1'b1;
        step();

        // Lone m1 read acked two cycles after grant.
        req_m1(32'h8000_0000);
        step();
        settle();
        chk("m1rd_addr", s_addr_o, 32'h8000_0000);
        chk("m1rd_we", {31'd0, s_we_o}, 32'd0);
        step();
        step();
        s_ack_i = 1'b1; s_dat_i = 32'h0000_0013;
        settle();
        chk("m1rd_ack", {31'd0, m1_ack_o}, 32'd1);
        chk("m1rd_dat", m1_dat_o, 32'h0000_0013);
        chk("m1rd_m0ack", {31'd0, m0_ack_o}, 32'd0);
        step();
        idle_all();
        step();

        // Tie right after reset: m0, then m1, then m0 again.
        rst_i = 1'b0;
        step();
        rst_i = 1'b1;
        req_m0(32'hA0); req_m1(32'hA1); m0_dat_i = 32'h5555_AAAA;
        step();
        settle();
        chk("tie1_addr", s_addr_o, 32'hA0);
        s_ack_i = 1'b1;
        settle();
        chk("tie1_m0ack", {31'd0, m0_ack_o}, 32'd1);
        chk("tie1_m1ack", {31'd0, m1_ack_o}, 32'd0);
        step();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        settle();
        chk("tie_gap_cyc", {31'd0, s_cyc_o}, 32'd0);
        step();
        settle();
        chk("tie2_addr", s_addr_o, 32'hA1);
        chk("tie2_sel", {28'd0, s_sel_o}, 32'hF);
        chk("tie2_sdat", s_dat_o, 32'd0);
        s_ack_i = 1'b1;
        settle();
        chk("tie2_m1ack", {31'd0, m1_ack_o}, 32'd1);
        step();
        s_ack_i = 1'b0; req_m0(32'hA0);
        step();
        settle();
        chk("tie3_addr", s_addr_o, 32'hA0);
        s_ack_i = 1'b1;
        step();
        idle_all();
        step();

        // m0 write with partial byte select.
        req_m0(32'h8000_0100); m0_dat_i = 32'hDEAD_BEEF; m0_sel_i = 4'b0011; m0_we_i = 1'b1;
        step();
        settle();
        chk("wr_we", {31'd0, s_we_o}, 32'd1);
        chk("wr_sel", {28'd0, s_sel_o}, 32'h3);
        chk("wr_dat", s_dat_o, 32'hDEAD_BEEF);
        chk("wr_addr", s_addr_o, 32'h8000_0100);
        s_ack_i = 1'b1;
        settle();
        chk("wr_ack", {31'd0, m0_ack_o}, 32'd1);
        step();
        idle_all();
        step();

        // ack and err together: err wins.
        req_m0(32'h44);
        step();
        s_ack_i = 1'b1; s_err_i = 1'b1;
        settle();
        chk("both_err", {31'd0, m0_err_o}, 32'd1);
        chk("both_ack", {31'd0, m0_ack_o}, 32'd0);
        step();
        idle_all();
        step();

        // Abort: m0 drops cyc mid-transfer.
        req_m0(32'h48);
        step();
        m0_cyc_i = 1'b0;
        settle();
        chk("abort_cyc", {31'd0, s_cyc_o}, 32'd0);
        step();
        m0_cyc_i = 1'b1;
        settle();
        chk("abort_idle", {31'd0, s_cyc_o}, 32'd0);
        idle_all();
        step();

        // m1 arrives while m0 owns the bus and must wait its turn.
        req_m0(32'hB0);
        step();
        req_m1(32'hB1);
        settle();
        chk("pend_addr0", s_addr_o, 32'hB0);
        step();
        settle();
        chk("pend_addr1", s_addr_o, 32'hB0);
        s_ack_i = 1'b1;
        settle();
        chk("pend_m0ack", {31'd0, m0_ack_o}, 32'd1);
        chk("pend_m1ack", {31'd0, m1_ack_o}, 32'd0);
        step();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        step();
        settle();
        chk("pend_served", s_addr_o, 32'hB1);
        chk("pend_cyc", {31'd0, s_cyc_o}, 32'd1);
        s_ack_i = 1'b1;
        step();
        idle_all();
        step();

        // Ack lands in the watchdog cycle: no timeout.
        req_m0(32'hC0);
        for (int c = 1; c <= TO; c++) step();
        s_ack_i = 1'b1;
        settle();
        chk("late_to", {31'd0, timeout_o}, 32'd0);
        chk("late_ack", {31'd0, m0_ack_o}, 32'd1);
        chk("late_err", {31'd0, m0_err_o}, 32'd0);
        step();
        idle_all();
        step();

        // Silent slave on m1: forced error in the TO-th grant cycle.
        req_m1(32'hD0);
        for (int c = 1; c <= TO; c++) begin
            step();
            settle();
            if (c < TO) begin
                chk("to_early", {31'd0, timeout_o}, 32'd0);
            end else begin
                chk("to_pulse", {31'd0, timeout_o}, 32'd1);
                chk("to_err", {31'd0, m1_err_o}, 32'd1);
                chk("to_ack", {31'd0, m1_ack_o}, 32'd0);
                chk("to_cyc", {31'd0, s_cyc_o}, 32'd0);
            end
        end
        step();
        settle();
        chk("to_idle_cyc", {31'd0, s_cyc_o}, 32'd0);
        chk("to_idle_to", {31'd0, timeout_o}, 32'd0);
        idle_all();
        step();

        // Reset while m1 waits: the next cycle shows nothing, even with a late ack.
        req_m1(32'hE0);
        step();
        step();
        rst_i = 1'b0;
        step();
        rst_i = 1'b1; s_ack_i = 1'b1; s_err_i = 1'b1;
        settle();
        chk("rstmid_cyc", {31'd0, s_cyc_o}, 32'd0);
        chk("rstmid_m1ack", {31'd0, m1_ack_o}, 32'd0);
        chk("rstmid_m1err", {31'd0, m1_err_o}, 32'd0);
        chk("rstmid_m0ack", {31'd0, m0_ack_o}, 32'd0);
        chk("rstmid_m0err", {31'd0, m0_err_o}, 32'd0);
        idle_all();
        step();
        step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, is the number of cycles a granted transfer may wait for slave ack/err before the arbiter forces an error; legal range 2..255.
REQ-002 clk_i  input  1  clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  synchronous, active-low reset.
REQ-004 m0 (data master) inputs: m0_addr_i 32, m0_dat_i 32, m0_sel_i 4, m0_we_i 1, m0_cyc_i 1, m0_stb_i 1.
REQ-005 m0 (data master) outputs: m0_dat_o 32, m0_ack_o 1, m0_err_o 1.
REQ-006 m1 (instruction master, read-only) inputs: m1_addr_i 32, m1_cyc_i 1, m1_stb_i 1.
REQ-007 m1 (instruction master, read-only) outputs: m1_dat_o 32, m1_ack_o 1, m1_err_o 1.
REQ-008 Slave outputs: s_addr_o 32, s_dat_o 32, s_sel_o 4, s_we_o 1, s_cyc_o 1, s_stb_o 1.
REQ-009 Slave inputs: s_dat_i 32, s_ack_i 1, s_err_i 1.
REQ-010 timeout_o  output  1  one-cycle pulse when a forced timeout error is issued.

Function
REQ-011 The state machine SHALL have exactly three states: IDLE, GNT_M0, GNT_M1.
REQ-012 A master requests when cyc_i & stb_i = 1.
REQ-013 In IDLE, a single requester SHALL move the FSM to its GNT state on the next edge.
REQ-014 In IDLE with both masters requesting, the master not equal to register last_gnt SHALL win (round-robin).
REQ-015 last_gnt SHALL update to the winner on every IDLE->GNT transition.
REQ-016 In IDLE, s_cyc_o, s_stb_o and s_we_o SHALL be 0; s_addr_o, s_dat_o and s_sel_o are don't-care.
REQ-017 In GNT_M0, the slave outputs SHALL equal the m0 inputs combinationally.
REQ-018 In GNT_M1, the slave outputs SHALL equal the m1 inputs combinationally, with s_we_o=0, s_sel_o=4'hF and s_dat_o=0.
REQ-019 s_dat_i SHALL be broadcast to m0_dat_o and m1_dat_o.
REQ-020 s_ack_i and s_err_i SHALL be routed only to the granted master, combinationally, in the same cycle; the non-granted master's ack/err SHALL be 0.
REQ-021 In a GNT state, s_ack_i=1 or s_err_i=1 SHALL end the transfer: FSM returns to IDLE on the next edge, so at least one IDLE cycle separates transfers.
REQ-022 If s_ack_i and s_err_i are both 1, err SHALL take precedence: the master sees err=1 and ack=0.
REQ-023 If the granted master drops cyc_i while in GNT (abort), the FSM SHALL return to IDLE on the next edge, with s_cyc_o following cyc_i combinationally.
REQ-024 An 8-bit wait counter SHALL clear on entry to a GNT state and increment on each GNT cycle without ack or err.
REQ-025 When the counter equals TIMEOUT_CYCLES-1 with no ack/err, the arbiter SHALL take all of the following actions in that cycle:
- drive the granted master's err=1;
- drive timeout_o=1;
- drive s_cyc_o=0 and s_stb_o=0;
- return to IDLE on the next edge.
REQ-026 A real ack/err arriving in the timeout cycle SHALL win, and timeout_o SHALL stay 0.
REQ-027 A request from the non-granted master during GNT SHALL be held pending; it is served after the current transfer, with no lost request and no grant switch mid-transfer.
REQ-028 The arbiter SHALL add no register stage on the request, address or data paths; the only added latency is one cycle in IDLE before grant.

Reset
REQ-029 While rst_i=0 at a rising edge, the following SHALL apply:
- state=IDLE;
- last_gnt=m1, so the first tie goes to m0;
- wait counter=0.
REQ-030 During and after reset, s_cyc_o, s_stb_o, s_we_o, all master ack/err outputs and timeout_o SHALL be 0 until a new grant.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer: no ack or err is delivered to either master in the following cycle.

Verification
REQ-032 Scenario: only m1 requests addr 0x8000_0000; slave acks 2 cycles after grant with data 0x0000_0013. Required response:
- s_addr_o=0x8000_0000 and s_we_o=0;
- m1_ack_o=1 with m1_dat_o=0x13;
- m0_ack_o=0 throughout.
REQ-033 Scenario: m0 and m1 request in the same cycle right after reset. Required response: m0 is granted first; after its ack and one IDLE cycle, m1 is granted; on the next tie, m0 is granted again.
REQ-034 Scenario: m0 write, addr 0x8000_0100, data 0xDEAD_BEEF, sel 4'b0011. Required response:
- slave sees we=1, sel=0011 and that data;
- m0_ack_o=1 on s_ack_i.
REQ-035 Scenario: TIMEOUT_CYCLES=4; slave never responds to m1. Required response:
- m1_err_o=1 and timeout_o=1 in the 4th GNT cycle;
- s_cyc_o=0 in that same cycle;
- FSM in IDLE on the next cycle.
REQ-036 Scenario: s_ack_i=1 and s_err_i=1 together during GNT_M0. Required response: m0_err_o=1 and m0_ack_o=0.
REQ-037 Scenario: rst_i driven to 0 during GNT_M1 while the slave is waiting. Required response: next cycle s_cyc_o=0, with no ack/err to either master.
